mqc_frame_builder: RTL and testbench

//  Parametrised successor of the telemetry/IQ packet assembler. Writes frames into an external

---
 rtl/mqc_frame_builder.sv | 230 +++++++++++++++++++++++
 tb/tb_mqc_frame_builder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mqc_frame_builder.sv
// +----------------------------------------------------------------------------+
// | mqc_frame_builder: assembles telemetry / IQ-capture frames into a buffer   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module mqc_frame_builder #(
  parameter int          pDAT_W   = 32,
  parameter int          pCH_NUM  = 17,
  parameter int          pSEG_LEN = 1024,
  parameter int          pCAP_LEN = 163800,
  parameter int          pIQ_W    = 12,
  parameter int          pADDR_W  = 18,
  parameter logic [15:0] pMAGIC   = 16'hAFA
) (
  input  logic                        iclk,
  input  logic                        ireset,
  input  logic                        istart,
  input  logic                        imode,
  input  logic                        iabort,
  input  logic                        isample,
  input  logic [pIQ_W-1:0]            idata_re,
  input  logic [pIQ_W-1:0]            idata_im,
  input  logic [pCH_NUM*pDAT_W-1:0]   ich_data,
  input  logic [pCH_NUM-1:0]          ich_mask,
  output logic                        owr_en,
  output logic [pADDR_W-1:0]          owr_addr,
  output logic [pDAT_W-1:0]           owr_data,
  output logic                        oframe_ready,
  output logic [pADDR_W-1:0]          oframe_len,
  input  logic                        iframe_ack,
  output logic                        obusy,
  output logic [7:0]                  oseq,
  output logic                        ooverrun
);

  localparam int                 c_half     = pDAT_W / 2;
  localparam int                 c_seg_w    = (pSEG_LEN > 1) ? $clog2(pSEG_LEN) : 1;
  localparam logic [c_seg_w-1:0] c_seg_last = c_seg_w'(pSEG_LEN - 1);
  localparam logic [pADDR_W-1:0] c_cap_last = pADDR_W'(pCAP_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_TLM_DATA = 3'd1,
    S_TLM_HDR  = 3'd2,
    S_CAP      = 3'd3,
    S_READY    = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [pCH_NUM-1:0]   mask_q, mask_d;
  logic [7:0]           ch_q, ch_d;
  logic [c_seg_w-1:0]   seg_q, seg_d;
  logic [pADDR_W-1:0]   addr_q, addr_d;
  logic                 wr_en_q, wr_en_d;
  logic [pADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [pDAT_W-1:0]    wr_data_q, wr_data_d;
  logic                 ready_q, ready_d;
  logic [pADDR_W-1:0]   len_q, len_d;
  logic [7:0]           seq_q, seq_d;
  logic                 ovr_q, ovr_d;

  logic [8:0]           w_first_ch;
  logic [8:0]           w_next_ch;
  logic [pDAT_W-1:0]    w_ch_word;
  logic [pDAT_W-1:0]    w_hdr_word;
  logic [pDAT_W-1:0]    w_iq_word;
  logic [c_half-1:0]    w_re_ext;
  logic [c_half-1:0]    w_im_ext;

  // Returns {found, index} of the lowest set mask bit at or above 'from'.
  function automatic logic [8:0] f_find_ch(input logic [pCH_NUM-1:0] mask, input int from);
    logic [8:0] res;
    res = '0;
    for (int k = pCH_NUM - 1; k >= 0; k--) begin
      if (mask[k] && (k >= from)) res = {1'b1, 8'(k)};
    end
    return res;
  endfunction

  always_comb begin
    w_first_ch = f_find_ch(ich_mask, 0);
    w_next_ch  = f_find_ch(mask_q, int'(ch_q) + 1);
    w_ch_word  = ich_data[int'(ch_q)*pDAT_W +: pDAT_W];

    w_hdr_word        = '0;
    w_hdr_word[31:24] = seq_q;
    w_hdr_word[23:16] = ch_q;
    w_hdr_word[15:0]  = pMAGIC;

    w_re_ext              = {c_half{idata_re[pIQ_W-1]}};
    w_re_ext[pIQ_W-1:0]   = idata_re;
    w_im_ext              = {c_half{idata_im[pIQ_W-1]}};
    w_im_ext[pIQ_W-1:0]   = idata_im;
    w_iq_word                     = '0;
    w_iq_word[2*c_half-1:c_half]  = w_re_ext;
    w_iq_word[c_half-1:0]         = w_im_ext;
  end

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    ch_d      = ch_q;
    seg_d     = seg_q;
    addr_d    = addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    ready_d   = ready_q;
    len_d     = len_q;
    seq_d     = seq_q;
    ovr_d     = 1'b0;

    if (iabort) begin
      state_d = S_IDLE;
      ready_d = 1'b0;
      len_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (istart) begin
            addr_d = '0;
            seg_d  = '0;
            if (imode) begin
              state_d = S_CAP;
            end else if (w_first_ch[8]) begin
              state_d = S_TLM_DATA;
              mask_d  = ich_mask;
              ch_d    = w_first_ch[7:0];
            end
          end
        end
        S_TLM_DATA: begin
          if (isample) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = w_ch_word;
            addr_d    = addr_q + 1'b1;
            if (seg_q == c_seg_last) begin
              seg_d   = '0;
              state_d = S_TLM_HDR;
            end else begin
              seg_d   = seg_q + 1'b1;
            end
          end
        end
        S_TLM_HDR: begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = w_hdr_word;
          addr_d    = addr_q + 1'b1;
          if (w_next_ch[8]) begin
            ch_d    = w_next_ch[7:0];
            state_d = S_TLM_DATA;
          end else begin
            state_d = S_READY;
            ready_d = 1'b1;
            len_d   = addr_q + 1'b1;
          end
        end
        S_CAP: begin
          if (isample) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = w_iq_word;
            addr_d    = addr_q + 1'b1;
            if (addr_q == c_cap_last) begin
              state_d = S_READY;
              ready_d = 1'b1;
              len_d   = addr_q + 1'b1;
            end
          end
        end
        S_READY: begin
          // The buffer belongs to the reader here, so a strobe can only be flagged.
          ovr_d = isample;
          if (iframe_ack) begin
            state_d = S_IDLE;
            ready_d = 1'b0;
            len_d   = '0;
            seq_d   = seq_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state_q   <= S_IDLE;
      mask_q    <= '0;
      ch_q      <= '0;
      seg_q     <= '0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ready_q   <= 1'b0;
      len_q     <= '0;
      seq_q     <= '0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      ch_q      <= ch_d;
      seg_q     <= seg_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ready_q   <= ready_d;
      len_q     <= len_d;
      seq_q     <= seq_d;
      ovr_q     <= ovr_d;
    end
  end

  assign owr_en       = wr_en_q;
  assign owr_addr     = wr_addr_q;
  assign owr_data     = wr_data_q;
  assign oframe_ready = ready_q;
  assign oframe_len   = len_q;
  assign obusy        = (state_q != S_IDLE);
  assign oseq         = seq_q;
  assign ooverrun     = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_mqc_frame_builder.sv
// +----------------------------------------------------------------------------+
// | tb_mqc_frame_builder: randomized frame-level bench for mqc_frame_builder   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mqc_frame_builder;

  localparam int DW  = 32;
  localparam int CH  = 3;
  localparam int SEG = 4;
  localparam int CAP = 5;
  localparam int IQW = 12;
  localparam int AW  = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              istart = 1'b0, imode = 1'b0, iabort = 1'b0, isample = 1'b0;
  logic [IQW-1:0]    idata_re = '0, idata_im = '0;
  logic [CH*DW-1:0]  ich_data = '0;
  logic [CH-1:0]     ich_mask = '0;
  logic              iframe_ack = 1'b0;
  logic              owr_en, oframe_ready, obusy, ooverrun;
  logic [AW-1:0]     owr_addr, oframe_len;
  logic [DW-1:0]     owr_data;
  logic [7:0]        oseq;

  int                n_checks = 0;
  int                n_errors = 0;
  logic [7:0]        exp_seq = '0;
  logic [DW-1:0]     exp_q[$];
  logic [AW-1:0]     obs_addr[$];
  logic [DW-1:0]     obs_data[$];

  mqc_frame_builder #(
    .pDAT_W(DW), .pCH_NUM(CH), .pSEG_LEN(SEG), .pCAP_LEN(CAP),
    .pIQ_W(IQW), .pADDR_W(AW), .pMAGIC(16'hAFA)
  ) dut (
    .iclk(clk), .ireset(rst), .istart(istart), .imode(imode), .iabort(iabort),
    .isample(isample), .idata_re(idata_re), .idata_im(idata_im),
    .ich_data(ich_data), .ich_mask(ich_mask), .owr_en(owr_en), .owr_addr(owr_addr),
    .owr_data(owr_data), .oframe_ready(oframe_ready), .oframe_len(oframe_len),
    .iframe_ack(iframe_ack), .obusy(obusy), .oseq(oseq), .ooverrun(ooverrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (owr_en) begin
      obs_addr.push_back(owr_addr);
      obs_data.push_back(owr_data);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int k = 0; k < CH; k++) ich_data[k*DW +: DW] = $urandom;
  endtask

  function automatic logic [DW-1:0] iq_word(input logic [IQW-1:0] re, input logic [IQW-1:0] im);
    int r, i;
    r = int'(re);
    i = int'(im);
    if (r >= 2048) r -= 4096;
    if (i >= 2048) i -= 4096;
    return {16'(r), 16'(i)};
  endfunction

  task automatic clear_frame();
    exp_q.delete();
    obs_addr.delete();
    obs_data.delete();
  endtask

  // Idle cycles inside a frame, with distracting istart/iframe_ack pulses.
  task automatic gap();
    repeat ($urandom_range(0, 2)) begin
      istart     = 1'($urandom);
      iframe_ack = 1'($urandom);
      rand_data();
      tick();
      istart     = 1'b0;
      iframe_ack = 1'b0;
    end
  endtask

  task automatic finish_frame();
    int n = 0;
    int nw;
    while (!oframe_ready && n < 10) begin
      tick();
      n++;
    end
    check("ready", oframe_ready, 1);
    check("len", oframe_len, exp_q.size());
    check("busy_ready", obusy, 1);
    @(negedge clk);
    #1;
    check("nwords", obs_addr.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_addr.size(); i++) begin
      check($sformatf("addr%0d", i), obs_addr[i], i);
      check($sformatf("data%0d", i), obs_data[i], exp_q[i]);
    end
    if ($urandom_range(0, 1) == 1) begin
      nw = obs_addr.size();
      isample = 1'b1;
      tick();
      isample = 1'b0;
      check("overrun", ooverrun, 1);
      tick();
      check("overrun_clr", ooverrun, 0);
      check("overrun_nowr", obs_addr.size(), nw);
    end
    iframe_ack = 1'b1;
    tick();
    iframe_ack = 1'b0;
    exp_seq++;
    check("idle_after_ack", obusy, 0);
    check("ready_clr", oframe_ready, 0);
    check("seq", oseq, exp_seq);
  endtask

  task automatic run_tlm(input logic [CH-1:0] mask);
    logic [DW-1:0] h;
    clear_frame();
    imode    = 1'b0;
    ich_mask = mask;
    istart   = 1'b1;
    tick();
    istart   = 1'b0;
    ich_mask = CH'($urandom);
    imode    = 1'($urandom);
    for (int k = 0; k < CH; k++) begin
      if (mask[k]) begin
        for (int w = 0; w < SEG; w++) begin
          rand_data();
          isample = 1'b1;
          exp_q.push_back(ich_data[k*DW +: DW]);
          tick();
          isample = 1'b0;
          if (w != SEG - 1) gap();
        end
        isample = 1'($urandom);
        tick();
        isample = 1'b0;
        check("hdr_no_overrun", ooverrun, 0);
        h        = '0;
        h[31:24] = exp_seq;
        h[23:16] = 8'(k);
        h[15:0]  = 16'h0AFA;
        exp_q.push_back(h);
      end
    end
    finish_frame();
  endtask

  task automatic run_cap(input bit fixed);
    clear_frame();
    imode  = 1'b1;
    istart = 1'b1;
    tick();
    istart = 1'b0;
    imode  = 1'b0;
    for (int i = 0; i < CAP; i++) begin
      idata_re = fixed ? 12'hFFF : IQW'($urandom);
      idata_im = fixed ? 12'h005 : IQW'($urandom);
      isample  = 1'b1;
      exp_q.push_back(iq_word(idata_re, idata_im));
      tick();
      isample  = 1'b0;
      if (i != CAP - 1) gap();
    end
    finish_frame();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"}, owr_en, 0);
    check({tag, "_wr_addr"}, owr_addr, 0);
    check({tag, "_wr_data"}, owr_data, 0);
    check({tag, "_ready"}, oframe_ready, 0);
    check({tag, "_len"}, oframe_len, 0);
    check({tag, "_busy"}, obusy, 0);
    check({tag, "_seq"}, oseq, 0);
    check({tag, "_ovr"}, ooverrun, 0);
  endtask

  initial begin
    logic [CH-1:0] m;
    int guard;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    run_tlm(3'b101);
    run_cap(1'b1);

    // Telemetry start with no channels enabled is ignored.
    clear_frame();
    imode = 1'b0; ich_mask = '0; istart = 1'b1;
    tick();
    istart = 1'b0;
    check("mask0_busy", obusy, 0);
    tick();
    check("mask0_nowr", obs_addr.size(), 0);

    // Abort mid-segment together with a sample.
    clear_frame();
    ich_mask = 3'b010; istart = 1'b1;
    tick();
    istart = 1'b0;
    isample = 1'b1; tick(); tick();
    iabort = 1'b1;
    tick();
    isample = 1'b0; iabort = 1'b0;
    check("abort_busy", obusy, 0);
    check("abort_ready", oframe_ready, 0);
    check("abort_seq", oseq, exp_seq);
    tick(); tick();
    check("abort_writes", obs_addr.size(), 2);

    for (int f = 0; f < 6; f++) begin
      m = CH'($urandom_range(1, 7));
      run_tlm(m);
    end
    for (int f = 0; f < 3; f++) run_cap(1'b0);

    guard = 0;
    while (exp_seq != 8'd0 && guard < 256) begin
      run_cap(1'b0);
      guard++;
    end
    check("seq_wrap", oseq, 8'd0);

    // Asynchronous reset in the middle of a capture.
    clear_frame();
    imode = 1'b1; istart = 1'b1;
    tick();
    istart = 1'b0;
    run_tlm_prefix_samples();
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    tick();
    rst = 1'b0;
    exp_seq = '0;
    tick();
    run_cap(1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  task automatic run_tlm_prefix_samples();
    idata_re = 12'h123; idata_im = 12'h456;
    isample = 1'b1;
    tick(); tick();
    isample = 1'b0;
  endtask

endmodule

`default_nettype wire
